pfd_pulse_decoder: RTL and testbench
====================================

Name: pfd_pulse_decoder

Overview:
Consumer side of the phase-frequency detector. Takes the PFD's UP/DN pulse outputs and synchronises them into the system clock domain. Measures each pulse width in clk cycles and emits one signed phase-error word per PFD event, with a single-cycle valid strobe. Sits between the PFD flip-flop pair and the digital loop filter.

Parameters:
- CNT_W, 8, width of phase_err (two's complement); magnitude saturates at 2^(CNT_W-1)-1.
- SYNC_STAGES, 2, synchroniser depth on up/dn; legal values are 2 or 3.

Ports:
- clk  input  1  system sampling clock; all state updates on the rising edge.
- cdn  input  1  asynchronous active-low reset (clear); one clock, reset is asynchronous and active-low.
- up  input  1  PFD UP pulse (reference leads); asynchronous to clk.
- dn  input  1  PFD DN pulse (feedback leads); asynchronous to clk.
- phase_err  output  CNT_W  signed error: +width for UP, -width for DN, 0 for coincident; registered.
- err_valid  output  1  one-cycle strobe; phase_err is valid only in this cycle.
- err_sat  output  1  high together with err_valid when the measured width was clipped.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (cdn=0, asynchronous):
  - synchroniser flops, count, phase_err, err_valid, err_sat and busy all go to 0; state goes to IDLE.
  - Reset mid-measurement discards the measurement; no valid is emitted after release.
- Synchronisation: up and dn each pass through SYNC_STAGES async-clear flops, giving up_s and dn_s. All FSM decisions use up_s/dn_s only.
- FSM states: IDLE, CNT_UP, CNT_DN, WAIT_LOW.
  - IDLE, up_s=1 and dn_s=0: go to CNT_UP, cnt=1.
  - IDLE, dn_s=1 and up_s=0: go to CNT_DN, cnt=1.
  - IDLE, both high: go to WAIT_LOW; emit phase_err=0, err_valid=1.
  - CNT_UP, up_s=1 and dn_s=0: cnt+1, saturating at 2^(CNT_W-1)-1; sat flag set when an increment is clipped.
  - CNT_UP, up_s=0: emit phase_err=+cnt, err_valid=1, err_sat=sat; go to IDLE.
  - CNT_UP, dn_s=1 (PFD reset overlap): emit +cnt as above; go to WAIT_LOW.
  - CNT_DN: mirror of CNT_UP with a negated result (-cnt).
  - WAIT_LOW: stay until up_s=0 and dn_s=0, then go to IDLE. No output is emitted.
- Latency (SYNC_STAGES=2): if up is sampled high on N consecutive edges t..t+N-1, then:
  - cnt reaches N;
  - err_valid is high for exactly the cycle following edge t+N+2.
- Output holding: err_valid is a one-cycle pulse. phase_err and err_sat hold their last values until the next valid; only err_valid strobes.
- Sat flag: cleared on every entry to CNT_UP or CNT_DN.
- Minimum gap: at least one IDLE cycle between events; back-to-back pulses separated by one low sample are both measured.
- Magnitude: never exceeds 2^(CNT_W-1)-1, so -cnt is always representable.

Decomposition:
- Shared package dpll_pkg holds:
  - state enum (IDLE, CNT_UP, CNT_DN, WAIT_LOW);
  - ERR_W default constant;
  - saturation-limit function.
- One sub-module, sync_n: a SYNC_STAGES-deep async-clear synchroniser, instantiated once for up and once for dn.
- The FSM and counter stay in the top module.

Test Plan:
- Reset: cdn=0 with up=1 asserted -> all outputs 0 and busy=0; after release with up held, first valid only after up goes low.
- UP width 5: up high for 5 clk edges -> single err_valid with phase_err=+5, err_sat=0, valid on the edge-t+7 cycle.
- DN width 3: dn high for 3 clk edges -> phase_err=-3 (8'hFD), one valid, busy deasserts the next cycle.
- Saturation (CNT_W=8): up high for 200 cycles -> phase_err=+127, err_sat=1; then a 2-cycle up -> +2, err_sat=0.
- Overlap: up high 4 cycles, dn rises in cycle 4, both drop 2 cycles later -> one valid +4 (±1 for sync skew, checked exactly with clk-aligned stimulus); no second valid until both are low.
- Coincident/mid reset: up and dn rise on the same edge -> phase_err=0 valid once. Separately, cdn pulsed low during a 10-cycle dn pulse -> no valid emitted for that pulse.

Source files
------------

// File: rtl/dpll_pkg.sv
// Shared types and constants for the digital PLL phase-error path.
package dpll_pkg;

  // Phase-error decoder FSM states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CNT_UP   = 2'd1,
    CNT_DN   = 2'd2,
    WAIT_LOW = 2'd3
  } state_t;

  // Default width of the signed phase-error word.
  localparam int ERR_W = 8;

  // Largest magnitude a w-bit two's complement error can carry with a
  // representable negation: 2^(w-1)-1.
  function automatic int sat_limit(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

endpackage

// File: rtl/sync_n.sv
// Multi-stage async-clear synchroniser for a single asynchronous bit.
// STAGES must be 2 or 3.
module sync_n #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic cdn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the raw input through the flop chain; the last stage is the clean copy.
  always_ff @(posedge clk or negedge cdn) begin
    if (!cdn) begin
      chain <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples the pre-edge value of its neighbour, as real hardware does.
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pfd_pulse_decoder.sv
// Converts PFD UP/DN pulses into one signed phase-error word per PFD event.
// The pulse width is measured in clk cycles after synchronisation; UP gives a
// positive result, DN a negative one, coincident edges give zero.
module pfd_pulse_decoder
  import dpll_pkg::*;
#(
  parameter int CNT_W       = ERR_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    cdn,
  input  logic                    up,
  input  logic                    dn,
  output logic signed [CNT_W-1:0] phase_err,
  output logic                    err_valid,
  output logic                    err_sat,
  output logic                    busy
);

  // Magnitude ceiling keeps -cnt representable in CNT_W bits.
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(sat_limit(CNT_W));

  logic up_s;
  logic dn_s;

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             sat;
  logic             sat_n;
  logic             emit;
  logic [CNT_W-1:0] emit_err;
  logic             emit_sat;

  sync_n #(.STAGES(SYNC_STAGES)) u_sync_up (
    .clk (clk),
    .cdn (cdn),
    .d   (up),
    .q   (up_s)
  );

  sync_n #(.STAGES(SYNC_STAGES)) u_sync_dn (
    .clk (clk),
    .cdn (cdn),
    .d   (dn),
    .q   (dn_s)
  );

  // Next-state, width counter and emitted result, decided from synchronised inputs only.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_n  = state;
    cnt_n    = cnt;
    sat_n    = sat;
    emit     = 1'b0;
    emit_err = '0;
    emit_sat = 1'b0;

    case (state)
      IDLE: begin
        if (up_s && dn_s) begin
          // Coincident edges: zero phase error, then wait for the PFD to clear.
          state_n = WAIT_LOW;
          emit    = 1'b1;
        end else if (up_s) begin
          state_n = CNT_UP;
          cnt_n   = CNT_W'(1);
          sat_n   = 1'b0;
        end else if (dn_s) begin
          state_n = CNT_DN;
          cnt_n   = CNT_W'(1);
          sat_n   = 1'b0;
        end
      end

      CNT_UP: begin
        if (!up_s || dn_s) begin
          // Pulse ended, or DN rose as the PFD began its reset overlap.
          emit     = 1'b1;
          emit_err = cnt;
          emit_sat = sat;
          state_n  = dn_s ? WAIT_LOW : IDLE;
        end else if (cnt == LIMIT) begin
          sat_n = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      CNT_DN: begin
        if (!dn_s || up_s) begin
          emit     = 1'b1;
          emit_err = '0 - cnt;
          emit_sat = sat;
          state_n  = up_s ? WAIT_LOW : IDLE;
        end else if (cnt == LIMIT) begin
          sat_n = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      WAIT_LOW: begin
        if (!up_s && !dn_s) begin
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, counter and registered outputs; the result words hold between strobes.
  always_ff @(posedge clk or negedge cdn) begin
    if (!cdn) begin
      state     <= IDLE;
      cnt       <= '0;
      sat       <= 1'b0;
      err_valid <= 1'b0;
      phase_err <= '0;
      err_sat   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      sat       <= sat_n;
      err_valid <= emit;
      if (emit) begin
        phase_err <= emit_err;
        err_sat   <= emit_sat;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_pfd_pulse_decoder.sv
// Directed self-checking bench for pfd_pulse_decoder (CNT_W=8, SYNC_STAGES=2).
// Inputs change 1 ns after a rising edge and outputs are sampled there too.
module tb_pfd_pulse_decoder;

  logic       clk = 1'b0;
  logic       cdn;
  logic       up;
  logic       dn;
  logic [7:0] phase_err;
  logic       err_valid;
  logic       err_sat;
  logic       busy;

  int total = 0;
  int bad   = 0;

  pfd_pulse_decoder #(.CNT_W(8), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .cdn       (cdn),
    .up        (up),
    .dn        (dn),
    .phase_err (phase_err),
    .err_valid (err_valid),
    .err_sat   (err_sat),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance n edges, counting how many samples show err_valid high.
  task automatic run_count(input int n, output int v);
    v = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (err_valid) v++;
    end
  endtask

  // Advance until err_valid is seen; return the edge index (1-based) or -1.
  task automatic wait_valid(input int max_edges, output int at);
    at = -1;
    for (int i = 1; i <= max_edges; i++) begin
      tick();
      if (err_valid) begin
        at = i;
        break;
      end
    end
  endtask

  int v;
  int at;

  initial begin
    cdn = 1'b0;
    up  = 1'b1;
    dn  = 1'b0;

    // Reset held with UP asserted: everything stays cleared.
    tick(); tick(); tick();
    check("rst_phase_err", phase_err, 8'h00);
    check("rst_valid", err_valid, 1'b0);
    check("rst_sat", err_sat, 1'b0);
    check("rst_busy", busy, 1'b0);

    // Release with UP still high for 6 more edges; result is +6 after UP drops.
    cdn = 1'b1;
    run_count(6, v);
    check("rst_no_early_valid", v, 0);
    up = 1'b0;
    wait_valid(10, at);
    check("rst_valid_latency", at, 3);
    check("rst_width", phase_err, 8'd6);
    run_count(4, v);

    // UP high for 5 edges t..t+4: valid exactly in the cycle after edge t+7.
    up = 1'b1;
    run_count(5, v);
    up = 1'b0;
    tick();
    check("up5_t5_valid", err_valid, 1'b0);
    tick();
    check("up5_t6_valid", err_valid, 1'b0);
    tick();
    check("up5_t7_valid", err_valid, 1'b1);
    check("up5_err", phase_err, 8'd5);
    check("up5_sat", err_sat, 1'b0);
    tick();
    check("up5_t8_valid", err_valid, 1'b0);
    check("up5_hold", phase_err, 8'd5);
    run_count(3, v);
    check("up5_single", v, 0);

    // DN high for 3 edges: -3 as 8'hFD, FSM idle right after the strobe.
    dn = 1'b1;
    run_count(3, v);
    dn = 1'b0;
    wait_valid(10, at);
    check("dn3_latency", at, 3);
    check("dn3_err", phase_err, 8'hFD);
    check("dn3_sat", err_sat, 1'b0);
    tick();
    check("dn3_valid_drop", err_valid, 1'b0);
    check("dn3_busy", busy, 1'b0);
    run_count(3, v);

    // Very long UP pulse clips to +127 with the saturation flag.
    up = 1'b1;
    run_count(200, v);
    check("sat_no_early_valid", v, 0);
    up = 1'b0;
    wait_valid(10, at);
    check("sat_latency", at, 3);
    check("sat_err", phase_err, 8'd127);
    check("sat_flag", err_sat, 1'b1);
    run_count(3, v);
    check("sat_hold_flag", err_sat, 1'b1);

    // Short UP after saturation: flag cleared on re-entry.
    up = 1'b1;
    run_count(2, v);
    up = 1'b0;
    wait_valid(10, at);
    check("up2_err", phase_err, 8'd2);
    check("up2_sat", err_sat, 1'b0);
    run_count(3, v);

    // Coincident rise: zero error, once, then no further strobe.
    up = 1'b1;
    dn = 1'b1;
    wait_valid(10, at);
    check("coin_latency", at, 3);
    check("coin_err", phase_err, 8'h00);
    check("coin_sat", err_sat, 1'b0);
    up = 1'b0;
    dn = 1'b0;
    run_count(8, v);
    check("coin_single", v, 0);
    check("coin_busy", busy, 1'b0);

    // Overlap: UP alone for 4 edges, then DN joins for 2 edges, both drop.
    // DN reaching the FSM ends the measurement at +4; WAIT_LOW emits nothing.
    up = 1'b1;
    run_count(4, v);
    dn = 1'b1;
    run_count(2, v);
    check("ovl_no_early_valid", v, 0);
    up = 1'b0;
    dn = 1'b0;
    tick();
    check("ovl_valid", err_valid, 1'b1);
    check("ovl_err", phase_err, 8'd4);
    tick();
    check("ovl_wait_busy", busy, 1'b1);
    run_count(8, v);
    check("ovl_single", v, 0);
    check("ovl_busy_end", busy, 1'b0);

    // Reset in the middle of a 10-edge DN pulse discards the measurement.
    dn = 1'b1;
    run_count(5, v);
    cdn = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_err", phase_err, 8'h00);
    check("mid_rst_valid", err_valid, 1'b0);
    run_count(5, v);
    dn = 1'b0;
    run_count(2, v);
    cdn = 1'b1;
    run_count(12, v);
    check("mid_rst_no_valid", v, 0);
    check("mid_rst_idle", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop so the bench can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
